// File: rtl/parity_frame_tx_if.sv
// Word handshake between the parity encoder (master) and the frame transmitter (slave).
// Carries the data word, its parity bit and the valid/ready pair.
interface parity_frame_tx_if #(
    parameter int unsigned DATA_W = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_parity, output in_valid, input in_ready);
    modport slave  (input in_data, input in_parity, input in_valid, output in_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start(0), data LSB-first, parity, stop(1) on an idle-high line.
// Define STOP2_EN to send two stop bits (tx_done moves out by one bit time).
module parity_frame_tx #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    parity_frame_tx_if.slave    in_bus,
    output logic                tx_out,
    output logic                busy,
    output logic                tx_done
);

`ifdef STOP2_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] data_q;
    logic              parity_q;
    logic              wrap;

    assign wrap = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            baud_cnt        <= '0;
            bit_idx         <= '0;
            data_q          <= '0;
            parity_q        <= 1'b0;
            tx_out          <= 1'b1;
            busy            <= 1'b0;
            tx_done         <= 1'b0;
            in_bus.in_ready <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= wrap ? '0 : baud_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    in_bus.in_ready <= 1'b1;
                    baud_cnt        <= '0;
                    bit_idx         <= '0;
                    if (in_bus.in_valid && in_bus.in_ready) begin
                        data_q          <= in_bus.in_data;
                        parity_q        <= in_bus.in_parity;
                        in_bus.in_ready <= 1'b0;
                        busy            <= 1'b1;
                        tx_out          <= 1'b0;
                        state           <= START;
                    end
                end
                // data_q shifts right each bit so the next bit to send is always bit 0
                START: begin
                    if (wrap) begin
                        tx_out  <= data_q[0];
                        data_q  <= data_q >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        if (bit_idx == DATA_LAST) begin
                            tx_out  <= parity_q;
                            bit_idx <= '0;
                            state   <= PARITY;
                        end else begin
                            tx_out  <= data_q[0];
                            data_q  <= data_q >> 1;
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (wrap) begin
                        tx_out  <= 1'b1;
                        bit_idx <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        if (bit_idx == STOP_LAST) begin
                            tx_done         <= 1'b1;
                            in_bus.in_ready <= 1'b1;
                            busy            <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Randomized bench for parity_frame_tx against a cycle-offset frame model.
// Build with STOP2_EN defined to exercise the two-stop-bit variant.
module tb_parity_frame_tx;

    localparam int DW  = 4;
    localparam int CPB = 4;
`ifdef STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int NB  = DW + 2 + NSTOP;
    localparam int FL  = NB * CPB;
    localparam int TMO = 4 * FL;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_out, busy, tx_done;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    parity_frame_tx_if #(.DATA_W(DW)) bus ();

    parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_bus  (bus),
        .tx_out  (tx_out),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference: off = edges since acceptance (0..FL-1 on the line, FL = done cycle),
    // -1 idle and ready, -2 first cycle after reset (not yet ready).
    int            off = -2;
    logic [NB-1:0] fbits = '1;
    logic          m_ready;
    assign m_ready = (off == -1) || (off == FL);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off <= -2;
        end else if (bus.in_valid && m_ready) begin
            off   <= 0;
            fbits <= {{NSTOP{1'b1}}, bus.in_parity, bus.in_data, 1'b0};
        end else if (off == -2) begin
            off <= -1;
        end else if (off >= 0 && off < FL) begin
            off <= off + 1;
        end else if (off == FL) begin
            off <= -1;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_out",   32'(tx_out),       32'((off >= 0 && off < FL) ? fbits[off / CPB] : 1'b1));
            check("busy",     32'(busy),         32'(off >= 0 && off < FL));
            check("tx_done",  32'(tx_done),      32'(off == FL));
            check("in_ready", 32'(bus.in_ready), 32'(m_ready));
        end
    end

    task automatic offer(input logic [DW-1:0] d, input logic p, input bit keep_valid, output int acc);
        bit got = 1'b0;
        acc = -1;
        bus.in_data   = d;
        bus.in_parity = p;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                got = 1'b1;
                if (!keep_valid) begin
                    bus.in_valid  = 1'b0;
                    bus.in_data   = DW'($urandom);
                    bus.in_parity = 1'($urandom);
                end
                break;
            end
        end
        if (!got) begin
            bus.in_valid = 1'b0;
            check("accept_timeout", 32'(got), 32'(1));
        end
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (tx_done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic reset_during(input int k);
        repeat (k) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_out",  32'(tx_out),  32'(1));
        check("rst_busy",    32'(busy),    32'(0));
        check("rst_tx_done", 32'(tx_done), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(bus.in_ready), 32'(1));
    endtask

    initial begin
        int a1, a2, dc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_parity = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(bus.in_ready), 32'(1));

        // known word, exact latency
        offer(4'b1011, 1'b1, 1'b0, a1);
        wait_done(dc);
        check("done_latency", 32'(dc - a1), 32'(FL));

        // back-to-back with valid held high
        offer(4'h3, 1'b0, 1'b1, a1);
        offer(4'hE, 1'b1, 1'b0, a2);
        check("b2b_spacing", 32'(a2 - a1), 32'(FL + 1));
        wait_done(dc);
        check("done_latency", 32'(dc - a2), 32'(FL));

        // valid pulse mid-frame is ignored
        offer(4'h9, 1'b0, 1'b0, a1);
        repeat (2 * CPB + 1) @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(dc);
        check("done_latency", 32'(dc - a1), 32'(FL));
        repeat (3) @(negedge clk);
        check("no_extra_frame", 32'(busy), 32'(0));

        // reset during data bit 2, then a clean frame
        offer(4'hA, 1'b1, 1'b0, a1);
        reset_during(3 * CPB + 1);
        offer(4'h5, 1'b0, 1'b0, a1);
        wait_done(dc);
        check("done_latency", 32'(dc - a1), 32'(FL));

        for (int n = 0; n < 30; n++) begin
            int mode = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            case (mode)
                0: begin
                    offer(DW'($urandom), 1'($urandom), 1'b0, a1);
                    wait_done(dc);
                    check("done_latency", 32'(dc - a1), 32'(FL));
                end
                1: begin
                    offer(DW'($urandom), 1'($urandom), 1'b1, a1);
                    offer(DW'($urandom), 1'($urandom), 1'b0, a2);
                    check("b2b_spacing", 32'(a2 - a1), 32'(FL + 1));
                    wait_done(dc);
                end
                2: begin
                    offer(DW'($urandom), 1'($urandom), 1'b0, a1);
                    repeat ($urandom_range(1, FL - 4)) @(negedge clk);
                    bus.in_valid = 1'b1;
                    bus.in_data  = DW'($urandom);
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    wait_done(dc);
                    check("done_latency", 32'(dc - a1), 32'(FL));
                end
                default: begin
                    offer(DW'($urandom), 1'($urandom), 1'b0, a1);
                    reset_during(int'($urandom_range(1, FL - 2)));
                end
            endcase
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
